// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte (start, 8 data bits
// LSB first, odd parity, stop) and checks the device ack bit. The shared PS/2
// lines are driven only through open-drain output enables.
// Optional build macro PS2_TX_RETRY_EN: on nack/timeout the byte is resent up
// to two more times before tx_err is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  // One extra count of headroom so the terminal value itself is representable
  // even when TIMEOUT_CYCLES is a power of two.
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t state, nxt;

  logic             clk_meta, clk_sync, data_meta, data_sync;
  logic             clk_filt, clk_fall;
  logic [FLT_W-1:0] flt_cnt;
  logic [8:0]       frame_q;   // {parity, D7..D0}
  logic [3:0]       bit_cnt;
  logic             data_q;    // registered data_oe level while in SEND
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             inh_done, timeout, nack, fail, done_evt, retry_ok;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Glitch filter: a new clock level needs FILTER_LEN consecutive equal samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_sync == clk_filt) begin
      flt_cnt  <= '0;
    end else if (flt_cnt == FLT_LAST) begin
      clk_filt <= clk_sync;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  // Strobe in the same cycle the filtered clock is about to go 1 -> 0
  assign clk_fall = clk_filt & ~clk_sync & (flt_cnt == FLT_LAST);

  assign inh_done = (inh_cnt == INH_LAST);
  assign timeout  = (state == S_SEND || state == S_ACK) && (to_cnt == TO_LAST);
  assign nack     = (state == S_ACK) && clk_fall && data_sync && !timeout;
  assign fail     = timeout | nack;
  assign done_evt = (state == S_WAIT_IDLE) && clk_filt && data_sync;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;

  assign retry_ok = (retry_cnt < 2'd2);

  // Failed-attempt count; cleared on a fresh accept and on success
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         retry_cnt <= '0;
    else if (state == S_IDLE && tx_valid) retry_cnt <= '0;
    else if (done_evt)                    retry_cnt <= '0;
    else if (fail && retry_ok)            retry_cnt <= retry_cnt + 1'b1;
  end
`else
  assign retry_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state logic; timeout wins over a simultaneous falling edge
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      if (tx_valid) nxt = S_INHIBIT;
      S_INHIBIT:   if (inh_done) nxt = S_START;
      S_START:     nxt = S_SEND;
      S_SEND: begin
        if (fail)                           nxt = retry_ok ? S_INHIBIT : S_IDLE;
        else if (clk_fall && bit_cnt == 4'd9) nxt = S_ACK;
      end
      S_ACK: begin
        if (fail)          nxt = retry_ok ? S_INHIBIT : S_IDLE;
        else if (clk_fall) nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (done_evt) nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  // Outputs: bus enables and handshake decoded from state
  always_comb begin
    tx_ready    = (state == S_IDLE);
    tx_busy     = (state != S_IDLE);
    ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
    ps2_data_oe = (state == S_START) || ((state == S_SEND) && data_q);
    tx_done     = done_evt;
    tx_err      = fail && !retry_ok;
  end

  // Frame latch, counters and the data bit presented after each falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      bit_cnt <= '0;
      data_q  <= 1'b0;
      inh_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (state == S_IDLE && tx_valid) frame_q <= {~^tx_data, tx_data};

      if (state != S_INHIBIT) inh_cnt <= '0;
      else if (!inh_done)     inh_cnt <= inh_cnt + 1'b1;

      if (state != S_SEND && state != S_ACK) to_cnt <= '0;
      else if (to_cnt != TO_LAST)            to_cnt <= to_cnt + 1'b1;

      if (state == S_START) begin
        bit_cnt <= '0;
        data_q  <= 1'b1;             // keep the start bit on the line until edge 1
      end else if (state == S_SEND && clk_fall && !timeout) begin
        if (bit_cnt != 4'd9) begin
          data_q  <= ~frame_q[bit_cnt];
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          data_q  <= 1'b0;           // stop bit: release data
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH  = 60;
  localparam int TO   = 3000;
  localparam int FLT  = 4;
  localparam int H    = 20;     // device half clock period in clk cycles
  localparam int WMAX = 2000;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  wire        ps2_data_in = dev_data & ~ps2_data_oe;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, inh_ph = 0, both_cnt = 0;
  logic prev_oe = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (ps2_clk_oe && !prev_oe) inh_ph++;
    prev_oe = ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept
  task automatic start_tx(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One host-to-device frame as seen by the device; bits[0]=start, [8:1]=data,
  // [9]=parity, [10]=stop. abort_at stops with the clock low after that edge.
  task automatic dev_serve(input bit nack_bit, input int glitch_at, input int abort_at,
                           output logic [10:0] bits, output int inh_len);
    int n;
    bits = '0; inh_len = 0; n = 0;
    while (!ps2_clk_oe && n < WMAX) begin @(negedge clk); n++; end
    check("inhibit_seen", ps2_clk_oe, 1);
    while (ps2_clk_oe && !ps2_data_oe && n < WMAX) begin inh_len++; @(negedge clk); n++; end
    while (ps2_clk_oe && n < WMAX) begin @(negedge clk); n++; end
    check("clk_released", ps2_clk_oe, 0);
    bits[0] = ps2_data_in;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_data = nack_bit;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (i == abort_at) return;
      dev_clk = 1'b1;
      repeat (H/2) @(negedge clk);
      if (i <= 10) bits[i] = ps2_data_in;
      if (i == glitch_at) begin dev_clk = 1'b0; @(negedge clk); dev_clk = 1'b1; end
      repeat (H/2) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  // Full acked transfer with frame checks
  task automatic send_ok(input string tag, input logic [7:0] d, input logic par, input int glitch_at);
    logic [10:0] b; int il, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(d);
    dev_serve(1'b0, glitch_at, 0, b, il);
    repeat (20) @(negedge clk);
    check({tag, "_inh_len"}, il, INH);
    check({tag, "_start"}, b[0], 0);
    check({tag, "_byte"}, b[8:1], d);
    check({tag, "_parity"}, b[9], par);
    check({tag, "_stop"}, b[10], 1);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_err"}, err_cnt - e0, 0);
  endtask

  initial begin
    logic [10:0] b; int il, n, t0, d0, e0, p0;

    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    send_ok("ed", 8'hED, 1'b1, 0);
    send_ok("x01", 8'h01, 1'b0, 0);
    send_ok("xff", 8'hFF, 1'b1, 0);

    // Device nacks every attempt
    d0 = done_cnt; e0 = err_cnt; p0 = inh_ph;
    start_tx(8'hF4);
    for (int a = 0; a < ATTEMPTS; a++) dev_serve(1'b1, 0, 0, b, il);
    repeat (20) @(negedge clk);
    check("nack_err", err_cnt - e0, 1);
    check("nack_done", done_cnt - d0, 0);
    check("nack_inhibits", inh_ph - p0, ATTEMPTS);

    // Device never clocks after release
    e0 = err_cnt; t0 = 0;
    start_tx(8'hFF);
    for (int a = 0; a < ATTEMPTS; a++) begin
      n = 0;
      while (!ps2_clk_oe && n < 3*TO) begin @(negedge clk); n++; end
      n = 0;
      while (ps2_clk_oe && n < WMAX) begin @(negedge clk); n++; end
      t0 = cyc;
    end
    check("to_release", ps2_clk_oe, 0);
    n = 0;
    while (!tx_err && n < TO + 50) begin @(negedge clk); n++; end
    check("to_err_seen", tx_err, 1);
    check("to_latency", cyc - t0, TO);
    @(negedge clk);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    check("to_ready", tx_ready, 1);
    repeat (10) @(negedge clk);
    check("to_err_count", err_cnt - e0, 1);

    // tx_valid held high with the data changing mid-transfer
    tx_data = 8'hED; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    dev_serve(1'b0, 0, 0, b, il);
    check("hold_byte", b[8:1], 8'hED);
    n = 0;
    while (!tx_done && n < 200) begin @(negedge clk); n++; end
    check("hold_done", tx_done, 1);
    check("hold_ready_at_done", tx_ready, 0);
    @(negedge clk);
    check("hold_ready_after", tx_ready, 1);
    @(negedge clk);
    check("hold_reaccept", tx_busy, 1);
    tx_valid = 1'b0;
    dev_serve(1'b0, 0, 0, b, il);
    check("hold_second_byte", b[8:1], 8'h55);
    check("hold_second_par", b[9], 1);
    repeat (20) @(negedge clk);

    // 1-cycle low glitch on the clock while sending bit 4
    send_ok("glitch", 8'hA5, 1'b1, 4);

    // Reset asserted with the clock low after edge 4 (D3 of 0x00 pulls data)
    start_tx(8'h00);
    dev_serve(1'b0, 0, 4, b, il);
    check("mid_busy", tx_busy, 1);
    check("mid_data_oe", ps2_data_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_clk_oe", ps2_clk_oe, 0);
    check("mid_rst_data_oe", ps2_data_oe, 0);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_busy", tx_busy, 0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_err_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It is the opposite direction to the ps2_keyboard receiver that feeds scan codes to get_panel. It drives the shared open-drain PS/2 clock and data lines through output-enable signals only, and hands the bus back to the receiver when idle.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ack bit (15 ms at 50 MHz)
FILTER_LEN, 4, consecutive equal samples required to accept a new ps2_clk level

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tx_data  in  8  command byte
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: byte sent, device acked
tx_err  out  1  one-cycle pulse: nack or timeout
ps2_clk_in  in  1  raw PS/2 clock pin level
ps2_data_in  in  1  raw PS/2 data pin level
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low

Behaviour:
- Reset, asynchronous active-low: every output is 0 except tx_ready = 1. State = IDLE, counters cleared, both oe low (bus released). Reset mid-transfer releases the bus on the same edge; the device recovers by its own timeout.
- Input conditioning:
  - ps2_clk_in passes through a 2-flop synchronizer, then the FILTER_LEN glitch filter.
  - A falling edge is a filtered 1->0 transition; it is a 1-cycle internal strobe.
  - ps2_data_in is 2-flop synchronized only.
- Frame: {start 0, D0..D7 LSB first, odd parity, stop 1, device ack 0}. Parity = ~^tx_data.
- IDLE:
  - tx_ready = 1.
  - On accept: latch tx_data and parity into a 9-bit shift register, clear counters, go to INHIBIT.
  - tx_valid while not ready is ignored; no queueing.
- INHIBIT: clk_oe = 1, data_oe = 0 for INHIBIT_CYCLES cycles, then go to START.
- START:
  - clk_oe = 1 and data_oe = 1 for exactly 1 cycle; this is the start bit.
  - Then clk_oe = 0, timeout counter cleared, go to SEND.
- SEND, bit counter 0..9 incremented on each falling edge:
  - Edges 1..8: data_oe = ~D[n-1].
  - Edge 9: data_oe = ~parity.
  - Edge 10: data_oe = 0 (stop bit; the line floats high), go to ACK.
  - data_oe changes only in the cycle after a falling-edge strobe; it is held between edges.
- ACK:
  - On the next falling edge, sample ps2_data_in.
  - 0: go to WAIT_IDLE.
  - 1: pulse tx_err, go to IDLE.
- WAIT_IDLE:
  - Wait for filtered clk = 1 and data = 1, then pulse tx_done and go to IDLE.
  - WAIT_IDLE is not covered by the timeout.
- Timeout:
  - Counts every cycle in SEND and ACK.
  - On reaching TIMEOUT_CYCLES: both oe = 0, pulse tx_err, go to IDLE. The timeout takes priority over a simultaneous falling edge.
- tx_done and tx_err are never asserted together. The earliest new accept is the cycle after the pulse.
- Counter widths: $clog2 of the respective parameter, minimum 1. Counters saturate and never wrap.

Optional Feature:
PS2_TX_RETRY_EN.
- Defined:
  - A 2-bit retry counter is added.
  - On nack or timeout with retries < 2: increment the counter and go back to INHIBIT with the latched byte. No tx_err pulse is given.
  - tx_err pulses only after the third failed attempt. The counter clears on accept and on tx_done.
- Undefined: the first failure pulses tx_err immediately. The retry logic is absent.

Test Plan:
- Reset asserted mid-SEND (after edge 4) -> same cycle: ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, tx_busy = 0.
- tx_data = 0xED, device model clocks at 12.5 kHz and acks -> clk_oe low for 5000 cycles. Sampled bits are 1,0,1,1,0,1,1,1, parity 1, stop 1. Exactly one tx_done pulse, no tx_err.
- tx_data = 0x01 -> parity bit 0. tx_data = 0xFF -> parity bit 1. Both acked -> one tx_done each.
- Device model drives ack bit = 1 -> one tx_err pulse, no tx_done. With PS2_TX_RETRY_EN: exactly 3 INHIBIT phases, then a single tx_err.
- Device never clocks after release -> tx_err exactly 750000 cycles after clk_oe falls to 0. Both oe = 0 from then on.
- tx_valid held high during a transfer with tx_data changing to 0x55 -> ignored; the transmitted byte stays 0xED. A new accept occurs only the cycle after tx_done.
- 1-cycle low glitch on ps2_clk_in mid-byte -> filtered out; bit count and data unchanged; tx_done still reached.
